// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, STATUS/CAUSE field positions,
// exception codes and the redirect FSM state type.
package cp0_pkg;

  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;

  localparam int         ST_IE         = 0;
  localparam int         ST_OVF        = 1;
  localparam int         ST_UNF        = 2;
  localparam int         ST_IM_LSB     = 8;
  localparam int         CAUSE_EXC_LSB = 2;
  localparam int         CAUSE_IP_LSB  = 8;

  localparam logic [4:0] EXC_INT       = 5'd0;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } cp0_state_e;

  // Writable STATUS bits: IE, OVF, UNF and one IM bit per interrupt line.
  function automatic logic [31:0] status_wmask(input int num_irq);
    return 32'h0000_0007 | (((32'd1 << num_irq) - 32'd1) << ST_IM_LSB);
  endfunction

endpackage

// File: rtl/cp0_frame_stack.sv
// Nesting stack of saved {STATUS,EPC} frames; a push while full overwrites
// the top frame instead of growing.
module cp0_frame_stack #(
  parameter int  DEPTH = 4,
  parameter int  W     = 64,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty,
  output logic [PW:0]  level
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW:0]   sp_r;
  logic [PW-1:0] top_idx_s;
  logic [PW-1:0] wr_idx_s;

  // Status flags, top-of-stack read and write slot selection.
  always_comb begin
    full      = (sp_r == (PW+1)'(DEPTH));
    empty     = (sp_r == {(PW+1){1'b0}});
    top_idx_s = PW'(sp_r - (PW+1)'(1));
    if (full) begin
      wr_idx_s = top_idx_s;
    end else begin
      wr_idx_s = sp_r[PW-1:0];
    end
    top   = mem_r[top_idx_s];
    level = sp_r;
  end

  // Frame storage and saturating stack pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_r <= {(PW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (push) begin
      mem_r[wr_idx_s] <= din;
      if (!full) begin
        sp_r <= sp_r + (PW+1)'(1);
      end else begin
        sp_r <= sp_r;
      end
    end else if (pop && !empty) begin
      sp_r <= sp_r - (PW+1)'(1);
    end else begin
      sp_r <= sp_r;
    end
  end

endmodule

// File: rtl/cp0_irq_nest.sv
// CP0 with STATUS/CAUSE/EPC, prioritised maskable interrupts, nested
// exception frames and a held redirect/ack handshake toward the pipeline.
module cp0_irq_nest
  import cp0_pkg::*;
#(
  parameter int          NUM_IRQ     = 8,
  parameter int          STACK_DEPTH = 4,
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0004,
  localparam int         LW          = $clog2(STACK_DEPTH) + 1,
  localparam int         IW          = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               exc_req,
  input  logic [4:0]         exc_code,
  input  logic [31:0]        pc,
  input  logic [31:0]        npc,
  input  logic               eret,
  input  logic               mtc0,
  input  logic [4:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               redirect,
  input  logic               redirect_ack,
  output logic [31:0]        exc_addr,
  output logic [NUM_IRQ-1:0] int_ack,
  output logic [LW-1:0]      nest_level
);

  localparam logic [31:0] STATUS_WMASK = status_wmask(NUM_IRQ);
  localparam logic [31:0] STICKY_MASK  = (32'd1 << ST_OVF) | (32'd1 << ST_UNF);

  cp0_state_e         state_r, state_n;
  logic [31:0]        status_r, epc_r, exc_addr_r;
  logic [4:0]         exc_code_r;
  logic [IW-1:0]      winner_r, winner_s;
  logic               int_entry_r;
  logic [NUM_IRQ-1:0] pending_s;
  logic               take_exc_s, take_int_s, take_eret_s, take_mtc0_s;
  logic               stk_full_s, stk_empty_s;
  logic [63:0]        stk_top_s;

  cp0_frame_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (64)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (take_exc_s | take_int_s),
    .pop   (take_eret_s & ~stk_empty_s),
    .din   ({status_r, epc_r}),
    .top   (stk_top_s),
    .full  (stk_full_s),
    .empty (stk_empty_s),
    .level (nest_level)
  );

  // Qualified pending lines; lowest index wins.
  always_comb begin
    pending_s = irq & status_r[ST_IM_LSB +: NUM_IRQ] & {NUM_IRQ{status_r[ST_IE]}};
    winner_s  = {IW{1'b0}};
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending_s[i]) begin
        winner_s = IW'(i);
      end else begin
        winner_s = winner_s;
      end
    end
  end

  // Event arbitration in IDLE: exception, then interrupt, then ERET, then mtc0.
  always_comb begin
    take_exc_s  = 1'b0;
    take_int_s  = 1'b0;
    take_eret_s = 1'b0;
    take_mtc0_s = 1'b0;
    if (state_r == IDLE) begin
      take_exc_s  = exc_req;
      take_int_s  = ~exc_req & (|pending_s) & ~stk_full_s;
      take_eret_s = ~exc_req & ~take_int_s & eret;
      take_mtc0_s = ~exc_req & ~take_int_s & ~eret & mtc0;
    end else begin
      take_exc_s  = 1'b0;
    end
  end

  // Next-state logic: any entry or return parks in REDIR until acknowledged.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (take_exc_s | take_int_s | take_eret_s) begin
          state_n = REDIR;
        end else begin
          state_n = IDLE;
        end
      end
      REDIR: begin
        if (redirect_ack) begin
          state_n = IDLE;
        end else begin
          state_n = REDIR;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Architectural registers and redirect bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_r    <= 32'd0;
      epc_r       <= 32'd0;
      exc_code_r  <= 5'd0;
      exc_addr_r  <= 32'd0;
      winner_r    <= {IW{1'b0}};
      int_entry_r <= 1'b0;
    end else if (take_exc_s) begin
      status_r    <= (status_r & ~(32'd1 << ST_IE)) | (stk_full_s ? (32'd1 << ST_OVF) : 32'd0);
      epc_r       <= pc;
      exc_code_r  <= exc_code;
      exc_addr_r  <= EXC_VECTOR;
      int_entry_r <= 1'b0;
    end else if (take_int_s) begin
      status_r    <= status_r & ~(32'd1 << ST_IE);
      epc_r       <= npc;
      exc_code_r  <= EXC_INT;
      exc_addr_r  <= EXC_VECTOR;
      winner_r    <= winner_s;
      int_entry_r <= 1'b1;
    end else if (take_eret_s) begin
      exc_addr_r  <= epc_r;
      int_entry_r <= 1'b0;
      if (!stk_empty_s) begin
        // Restored STATUS keeps the live sticky flags so overflow history survives.
        status_r <= (stk_top_s[63:32] & ~STICKY_MASK) | (status_r & STICKY_MASK);
        epc_r    <= stk_top_s[31:0];
      end else begin
        status_r <= status_r | (32'd1 << ST_UNF);
      end
    end else if (take_mtc0_s) begin
      case (addr)
        ADDR_STATUS: status_r   <= wdata & STATUS_WMASK;
        ADDR_CAUSE:  exc_code_r <= wdata[CAUSE_EXC_LSB +: 5];
        ADDR_EPC:    epc_r      <= wdata;
        default:     status_r   <= status_r;
      endcase
    end else begin
      status_r <= status_r;
    end
  end

  // Acknowledge pulse and mfc0 read mux.
  always_comb begin
    int_ack = {NUM_IRQ{1'b0}};
    if ((state_r == REDIR) && redirect_ack && int_entry_r) begin
      int_ack[winner_r] = 1'b1;
    end else begin
      int_ack = {NUM_IRQ{1'b0}};
    end
    rdata = 32'd0;
    case (addr)
      ADDR_STATUS: rdata = status_r;
      ADDR_CAUSE: begin
        rdata[CAUSE_EXC_LSB +: 5]      = exc_code_r;
        rdata[CAUSE_IP_LSB +: NUM_IRQ] = irq;
      end
      ADDR_EPC:    rdata = epc_r;
      default:     rdata = 32'd0;
    endcase
  end

  assign redirect = (state_r == REDIR);
  assign exc_addr = exc_addr_r;

endmodule

// File: tb/tb_cp0_irq_nest.sv
// Self-checking bench for cp0_irq_nest: directed scenarios plus random traffic
// compared against a queue-based behavioural model of the CP0.
module tb_cp0_irq_nest;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq;
  logic        exc_req, eret, mtc0, redirect_ack;
  logic [4:0]  exc_code, addr;
  logic [31:0] pc, npc, wdata, rdata, exc_addr;
  logic        redirect;
  logic [7:0]  int_ack;
  logic [2:0]  nest_level;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit          m_redir;
  logic [31:0] m_status, m_epc, m_exc_addr;
  logic [4:0]  m_code;
  logic [63:0] m_stack[$];
  bit          m_int;
  int          m_win;

  cp0_irq_nest dut (
    .clk(clk), .rst(rst), .irq(irq), .exc_req(exc_req), .exc_code(exc_code),
    .pc(pc), .npc(npc), .eret(eret), .mtc0(mtc0), .addr(addr), .wdata(wdata),
    .rdata(rdata), .redirect(redirect), .redirect_ack(redirect_ack),
    .exc_addr(exc_addr), .int_ack(int_ack), .nest_level(nest_level)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_redir = 0; m_status = 32'd0; m_epc = 32'd0; m_exc_addr = 32'd0;
    m_code = 5'd0; m_stack.delete(); m_int = 0; m_win = 0;
  endtask

  task automatic model_tick();
    logic [7:0]  pend;
    logic [63:0] fr;
    if (!m_redir) begin
      pend = irq & m_status[15:8] & {8{m_status[0]}};
      if (exc_req) begin
        if (m_stack.size() == SD) begin
          m_stack[SD-1] = {m_status, m_epc};
          m_status[1] = 1'b1;
        end else begin
          m_stack.push_back({m_status, m_epc});
        end
        m_status[0] = 1'b0; m_epc = pc; m_code = exc_code;
        m_exc_addr = 32'h4; m_int = 0; m_redir = 1;
      end else if (pend != 8'd0 && m_stack.size() < SD) begin
        m_stack.push_back({m_status, m_epc});
        m_status[0] = 1'b0; m_epc = npc; m_code = 5'd0;
        m_exc_addr = 32'h4; m_int = 1; m_redir = 1;
        for (int i = 0; i < 8; i++) begin
          if (pend[i]) begin m_win = i; break; end
        end
      end else if (eret) begin
        m_exc_addr = m_epc; m_int = 0; m_redir = 1;
        if (m_stack.size() > 0) begin
          fr = m_stack.pop_back();
          m_status = {fr[63:35], m_status[2:1], fr[32]};
          m_epc = fr[31:0];
        end else begin
          m_status[2] = 1'b1;
        end
      end else if (mtc0) begin
        case (addr)
          5'd12: m_status = wdata & 32'h0000_FF07;
          5'd13: m_code = wdata[6:2];
          5'd14: m_epc = wdata;
          default: ;
        endcase
      end
    end else if (redirect_ack) begin
      m_redir = 0;
    end
  endtask

  function automatic logic [31:0] exp_rdata();
    case (addr)
      5'd12:   return m_status;
      5'd13:   return {16'd0, irq, 1'b0, m_code, 2'b00};
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack();
    redirect_ack = 1'b1; tick(); redirect_ack = 1'b0;
  endtask

  task automatic do_mtc0(input logic [4:0] a, input logic [31:0] d);
    addr = a; wdata = d; mtc0 = 1'b1; tick(); mtc0 = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1; tick(); eret = 1'b0; ack();
  endtask

  task automatic test_reset();
    rst = 1'b0; irq = 8'd0; exc_req = 1'b0; exc_code = 5'd0; pc = 32'd0; npc = 32'd0;
    eret = 1'b0; mtc0 = 1'b0; addr = 5'd12; wdata = 32'd0; redirect_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %0b want 0", redirect); end
    checks++; if (exc_addr !== 32'd0) begin errors++; $display("FAIL reset_exc_addr: got %h want 0", exc_addr); end
    checks++; if (int_ack !== 8'd0) begin errors++; $display("FAIL reset_int_ack: got %b want 0", int_ack); end
    checks++; if (nest_level !== 3'd0) begin errors++; $display("FAIL reset_nest: got %0d want 0", nest_level); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_status: got %h want 0", rdata); end
    addr = 5'd13; #1;
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_cause: got %h want 0", rdata); end
    rst = 1'b1; #1;
  endtask

  task automatic test_irq_entry();
    do_mtc0(5'd12, 32'h0000_0301);
    addr = 5'd12; #1;
    checks++; if (rdata !== 32'h0000_0301) begin errors++; $display("FAIL mtc0_status: got %h want 00000301", rdata); end
    npc = 32'h40; irq = 8'b10;
    tick();
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL irq_redirect: got %0b want 1", redirect); end
    checks++; if (exc_addr !== 32'h4) begin errors++; $display("FAIL irq_vector: got %h want 4", exc_addr); end
    addr = 5'd14; #1;
    checks++; if (rdata !== 32'h40) begin errors++; $display("FAIL irq_epc: got %h want 40", rdata); end
    addr = 5'd13; #1;
    checks++; if (rdata[6:2] !== 5'd0) begin errors++; $display("FAIL irq_exccode: got %0d want 0", rdata[6:2]); end
    addr = 5'd12; #1;
    checks++; if (rdata[0] !== 1'b0) begin errors++; $display("FAIL irq_ie_clear: got %0b want 0", rdata[0]); end
    redirect_ack = 1'b1; #1;
    checks++; if (int_ack !== 8'b10) begin errors++; $display("FAIL irq_int_ack: got %b want 00000010", int_ack); end
    tick(); redirect_ack = 1'b0;
    checks++; if (redirect !== 1'b0 || int_ack !== 8'd0) begin errors++; $display("FAIL irq_ack_done: got redirect=%0b int_ack=%b want 0/0", redirect, int_ack); end
  endtask

  task automatic test_priority();
    logic [31:0] npc1, npc2;
    irq = 8'd0; eret = 1'b1; tick(); eret = 1'b0;
    checks++; if (exc_addr !== 32'h40) begin errors++; $display("FAIL eret_target: got %h want 40", exc_addr); end
    ack();
    npc1 = $urandom & 32'hFFFF_FFFC; npc = npc1; irq = 8'b11;
    tick();
    redirect_ack = 1'b1; #1;
    checks++; if (int_ack !== 8'b01) begin errors++; $display("FAIL prio_int_ack: got %b want 00000001", int_ack); end
    tick(); redirect_ack = 1'b0;
    irq = 8'b10; npc = 32'h0; eret = 1'b1; tick(); eret = 1'b0;
    checks++; if (exc_addr !== npc1) begin errors++; $display("FAIL prio_eret_addr: got %h want %h", exc_addr, npc1); end
    ack();
    npc2 = $urandom & 32'hFFFF_FFFC; npc = npc2;
    tick();
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL prio_second_entry: got %0b want 1", redirect); end
    redirect_ack = 1'b1; #1;
    checks++; if (int_ack !== 8'b10) begin errors++; $display("FAIL prio_second_ack: got %b want 00000010", int_ack); end
    tick(); redirect_ack = 1'b0;
    irq = 8'd0; eret = 1'b1; tick(); eret = 1'b0;
    checks++; if (exc_addr !== npc2) begin errors++; $display("FAIL prio_second_eret: got %h want %h", exc_addr, npc2); end
    ack();
  endtask

  task automatic test_exc_over_irq();
    logic [31:0] pcv;
    pcv = $urandom & 32'hFFFF_FFFC;
    irq = 8'b01; exc_req = 1'b1; exc_code = 5'd8; pc = pcv;
    tick(); exc_req = 1'b0;
    addr = 5'd13; #1;
    checks++; if (rdata[6:2] !== 5'd8) begin errors++; $display("FAIL exc_code: got %0d want 8", rdata[6:2]); end
    addr = 5'd14; #1;
    checks++; if (rdata !== pcv) begin errors++; $display("FAIL exc_epc: got %h want %h", rdata, pcv); end
    redirect_ack = 1'b1; #1;
    checks++; if (int_ack !== 8'd0) begin errors++; $display("FAIL exc_no_int_ack: got %b want 0", int_ack); end
    tick(); redirect_ack = 1'b0;
    irq = 8'd0; do_eret();
  endtask

  task automatic test_overflow();
    irq = 8'd0; do_mtc0(5'd12, 32'h0000_0301); irq = 8'b01;
    for (int k = 0; k < SD; k++) begin
      npc = 32'h1000 + 32'(k * 4);
      tick(); ack(); do_mtc0(5'd12, 32'h0000_0301);
    end
    repeat (2) tick();
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL full_irq_blocked: got %0b want 0", redirect); end
    checks++; if (nest_level !== 3'd4) begin errors++; $display("FAIL full_nest: got %0d want 4", nest_level); end
    exc_req = 1'b1; exc_code = 5'd12; pc = $urandom; tick(); exc_req = 1'b0;
    addr = 5'd12; #1;
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL full_exc_taken: got %0b want 1", redirect); end
    checks++; if (rdata[1] !== 1'b1) begin errors++; $display("FAIL full_ovf: got %0b want 1", rdata[1]); end
    checks++; if (nest_level !== 3'd4) begin errors++; $display("FAIL full_exc_nest: got %0d want 4", nest_level); end
    ack(); irq = 8'd0;
    for (int k = 0; k < SD; k++) begin
      eret = 1'b1; tick(); eret = 1'b0;
      checks++; if (exc_addr !== m_exc_addr) begin errors++; $display("FAIL unwind_addr: got %h want %h", exc_addr, m_exc_addr); end
      ack();
    end
    addr = 5'd12; #1;
    checks++; if (rdata[1] !== 1'b1 || nest_level !== 3'd0) begin errors++; $display("FAIL ovf_sticky: got ovf=%0b nest=%0d want 1/0", rdata[1], nest_level); end
  endtask

  task automatic test_underflow();
    do_mtc0(5'd14, 32'h100);
    eret = 1'b1; tick(); eret = 1'b0;
    addr = 5'd12; #1;
    checks++; if (exc_addr !== 32'h100) begin errors++; $display("FAIL unf_addr: got %h want 100", exc_addr); end
    checks++; if (rdata[2] !== 1'b1) begin errors++; $display("FAIL unf_flag: got %0b want 1", rdata[2]); end
    ack();
  endtask

  task automatic test_hold_and_reset();
    logic [31:0] pcv;
    pcv = $urandom; exc_req = 1'b1; exc_code = 5'd9; pc = pcv; tick();
    addr = 5'd14;
    for (int k = 0; k < 5; k++) begin
      exc_req = 1'($urandom); pc = $urandom; eret = 1'($urandom);
      mtc0 = 1'b1; wdata = $urandom; irq = 8'($urandom);
      tick();
      checks++; if (redirect !== 1'b1 || exc_addr !== 32'h4 || rdata !== pcv) begin errors++; $display("FAIL hold_redir: got redirect=%0b addr=%h epc=%h want 1/4/%h", redirect, exc_addr, rdata, pcv); end
    end
    exc_req = 1'b0; eret = 1'b0; mtc0 = 1'b0; irq = 8'd0;
    rst = 1'b0; #1; model_reset();
    checks++; if (redirect !== 1'b0 || exc_addr !== 32'd0 || int_ack !== 8'd0 || nest_level !== 3'd0 || rdata !== 32'd0) begin errors++; $display("FAIL midredir_reset: got redirect=%0b addr=%h ack=%b nest=%0d epc=%h want all 0", redirect, exc_addr, int_ack, nest_level, rdata); end
    rst = 1'b1; #1;
  endtask

  task automatic test_random();
    int r;
    logic [31:0] er;
    logic [7:0]  ea;
    for (int c = 0; c < 600; c++) begin
      irq = 8'($urandom) & 8'($urandom);
      exc_req = ($urandom_range(0, 7) == 0);
      exc_code = 5'($urandom_range(1, 31));
      pc = $urandom; npc = $urandom;
      eret = ($urandom_range(0, 4) == 0);
      mtc0 = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 4);
      addr = (r == 0) ? 5'd12 : (r == 1) ? 5'd13 : (r == 2) ? 5'd14 : 5'($urandom);
      wdata = $urandom;
      redirect_ack = 1'($urandom);
      #1;
      er = exp_rdata();
      ea = (m_redir && redirect_ack && m_int) ? (8'd1 << m_win) : 8'd0;
      checks++; if (redirect !== m_redir) begin errors++; $display("FAIL rnd_redirect cyc %0d: got %0b want %0b", c, redirect, m_redir); end
      checks++; if (exc_addr !== m_exc_addr) begin errors++; $display("FAIL rnd_exc_addr cyc %0d: got %h want %h", c, exc_addr, m_exc_addr); end
      checks++; if (nest_level !== 3'(m_stack.size())) begin errors++; $display("FAIL rnd_nest cyc %0d: got %0d want %0d", c, nest_level, m_stack.size()); end
      checks++; if (int_ack !== ea) begin errors++; $display("FAIL rnd_int_ack cyc %0d: got %b want %b", c, int_ack, ea); end
      checks++; if (rdata !== er) begin errors++; $display("FAIL rnd_rdata cyc %0d addr %0d: got %h want %h", c, addr, rdata, er); end
      tick();
    end
    irq = 8'd0; exc_req = 1'b0; eret = 1'b0; mtc0 = 1'b0; redirect_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_irq_entry();
    test_priority();
    test_exc_over_irq();
    test_overflow();
    test_underflow();
    test_hold_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
